// File: rtl/ss_pkg.sv
// Shared state encodings, FIFO geometry and address helper for the
// scatter-gather read engine.
package ss_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AW    = 3;

    typedef logic [FIFO_AW:0] fifo_cnt_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_HOLD = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    // Word-step through the source buffer; wraps naturally at 4 GiB.
    function automatic logic [31:0] nextWordAddr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/ss_fifo.sv
// Synchronous 8x32 FIFO with a zero-latency head; a full FIFO still
// accepts a push when the head is popped in the same cycle.
module ss_fifo
    import ss_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [31:0]     data_i,
    output logic [31:0]     data_o,
    output logic            full_o,
    output logic            empty_o,
    output fifo_cnt_t       count_o
);

    logic [31:0]        mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wrPtr_q;
    logic [FIFO_AW-1:0] rdPtr_q;
    fifo_cnt_t          count_q;
    logic               doPush;
    logic               doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == fifo_cnt_t'(FIFO_DEPTH));
    assign count_o = count_q;
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);

    // An empty FIFO presents zero so dout stays quiet during reset and idle.
    assign data_o  = empty_o ? 32'd0 : mem_q[rdPtr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (doPush && !doPop) begin
                count_q <= count_q + 1'b1;
            end else if (doPop && !doPush) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ss_xfer_rd.sv
// Descriptor-driven Wishbone read engine: fetches sg_desc words from the
// descriptor address into a local FIFO, with retry, error and back-pressure.
module ss_xfer_rd
    import ss_pkg::*;
(
    input  logic            wb_clk_i,
    input  logic            wb_rst_n,
    input  logic            ss_xfer,
    input  logic [31:3]     sg_addr,
    input  logic [15:0]     sg_desc,
    input  logic            ss_last,
    output logic            wbm_cyc,
    output logic            wbm_stb,
    output logic            wbm_we,
    output logic            wbm_cab,
    output logic [3:0]      wbm_sel,
    output logic [31:0]     wbm_adr,
    input  logic [31:0]     wbm_dat_i,
    input  logic            wbm_ack,
    input  logic            wbm_err,
    input  logic            wbm_rty,
    output logic            ss_done,
    output logic            xfer_err,
    output logic            c_end,
    output logic [31:0]     dout,
    output logic            dvalid,
    input  logic            drd,
    input  logic            err_clr
);

    logic [2:0]  state_q,    state_d;
    logic [31:0] addr_q,     addr_d;
    logic [15:0] remCount_q, remCount_d;
    logic        last_q,     last_d;
    logic        cyc_q,      cyc_d;
    logic        stb_q,      stb_d;
    logic        xferErr_q,  xferErr_d;

    logic        ackHit;
    logic        errHit;
    logic        rtyHit;
    logic        fifoPop;
    logic        fifoFull;
    logic        fifoEmpty;
    fifo_cnt_t   fifoCount;
    logic        fifoFullNext;

    // Bus responses only count against a strobe we actually issued; err beats ack beats rty.
    assign errHit  = (state_q == ST_RD) && stb_q && wbm_err;
    assign ackHit  = (state_q == ST_RD) && stb_q && wbm_ack && !wbm_err;
    assign rtyHit  = (state_q == ST_RD) && stb_q && wbm_rty && !wbm_ack && !wbm_err;
    assign fifoPop = drd && !fifoEmpty;

    // Occupancy after this edge decides whether the registered strobe may rise.
    assign fifoFullNext = (fifoFull && !fifoPop) ||
                          ((fifoCount == fifo_cnt_t'(FIFO_DEPTH - 1)) && ackHit && !fifoPop);

    ss_fifo u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_n),
        .push_i  (ackHit),
        .pop_i   (drd),
        .data_i  (wbm_dat_i),
        .data_o  (dout),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remCount_d = remCount_q;
        last_d     = last_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        case (state_q)
            ST_IDLE: begin
                if (ss_xfer) begin
                    addr_d     = {sg_addr, 3'b000};
                    remCount_d = sg_desc;
                    last_d     = ss_last;
                    if (sg_desc == 16'd0) begin
                        state_d = ST_DONE;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                    end else begin
                        state_d = fifoFullNext ? ST_HOLD : ST_RD;
                        cyc_d   = 1'b1;
                        stb_d   = !fifoFullNext;
                    end
                end
            end
            ST_RD: begin
                if (errHit) begin
                    state_d = ST_ERR;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                end else if (ackHit) begin
                    addr_d     = nextWordAddr(addr_q);
                    remCount_d = remCount_q - 16'd1;
                    if (remCount_q == 16'd1) begin
                        state_d = ST_DONE;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                    end else if (fifoFullNext) begin
                        state_d = ST_HOLD;
                        stb_d   = 1'b0;
                    end else begin
                        stb_d   = 1'b1;
                    end
                end else if (rtyHit) begin
                    stb_d = 1'b0;
                end else if (!stb_q) begin
                    // End of the one-cycle retry gap: reissue the same address.
                    if (fifoFullNext) begin
                        state_d = ST_HOLD;
                    end else begin
                        stb_d   = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!fifoFullNext) begin
                    state_d = ST_RD;
                    stb_d   = 1'b1;
                end
            end
            ST_DONE, ST_ERR: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    // A fresh bus error outranks a software clear arriving in the same cycle.
    always_comb begin
        xferErr_d = xferErr_q;
        if (errHit) begin
            xferErr_d = 1'b1;
        end else if (err_clr) begin
            xferErr_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= 32'd0;
            remCount_q <= 16'd0;
            last_q     <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            xferErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remCount_q <= remCount_d;
            last_q     <= last_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            xferErr_q  <= xferErr_d;
        end
    end

    assign wbm_cyc  = cyc_q;
    assign wbm_stb  = stb_q;
    assign wbm_we   = 1'b0;
    assign wbm_sel  = cyc_q ? 4'hF : 4'h0;
    assign wbm_adr  = addr_q;
    assign wbm_cab  = (state_q == ST_RD) && (remCount_q > 16'd1);
    assign ss_done  = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign c_end    = (state_q == ST_DONE) && last_q;
    assign xfer_err = xferErr_q;
    assign dvalid   = !fifoEmpty;

endmodule

// File: tb/tb_ss_xfer_rd.sv
// Directed bench for ss_xfer_rd: the initial block plays both the
// descriptor source and the Wishbone slave, one step per clock.
module tb_ss_xfer_rd;

    logic        wb_clk_i;
    logic        wb_rst_n;
    logic        ss_xfer;
    logic [31:3] sg_addr;
    logic [15:0] sg_desc;
    logic        ss_last;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic        wbm_we;
    logic        wbm_cab;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack;
    logic        wbm_err;
    logic        wbm_rty;
    logic        ss_done;
    logic        xfer_err;
    logic        c_end;
    logic [31:0] dout;
    logic        dvalid;
    logic        drd;
    logic        err_clr;

    int assertCount;
    int failCount;
    int ackIdx;
    int popIdx;
    bit doneSeen;

    ss_xfer_rd dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_n  (wb_rst_n),
        .ss_xfer   (ss_xfer),
        .sg_addr   (sg_addr),
        .sg_desc   (sg_desc),
        .ss_last   (ss_last),
        .wbm_cyc   (wbm_cyc),
        .wbm_stb   (wbm_stb),
        .wbm_we    (wbm_we),
        .wbm_cab   (wbm_cab),
        .wbm_sel   (wbm_sel),
        .wbm_adr   (wbm_adr),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack   (wbm_ack),
        .wbm_err   (wbm_err),
        .wbm_rty   (wbm_rty),
        .ss_done   (ss_done),
        .xfer_err  (xfer_err),
        .c_end     (c_end),
        .dout      (dout),
        .dvalid    (dvalid),
        .drd       (drd),
        .err_clr   (err_clr)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One-cycle descriptor pulse; returns just after the edge that sampled it.
    task automatic applyStimulus(input logic [31:3] addr, input logic [15:0] desc,
                                 input logic last);
        sg_addr = addr;
        sg_desc = desc;
        ss_last = last;
        ss_xfer = 1'b1;
        tick();
        ss_xfer = 1'b0;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        wb_rst_n    = 1'b0;
        ss_xfer     = 1'b0;
        sg_addr     = '0;
        sg_desc     = 16'd0;
        ss_last     = 1'b0;
        wbm_dat_i   = 32'd0;
        wbm_ack     = 1'b0;
        wbm_err     = 1'b0;
        wbm_rty     = 1'b0;
        drd         = 1'b0;
        err_clr     = 1'b0;

        $display("[TB] reset state");
        repeat (3) tick();
        checkOutput("rst_cyc",    wbm_cyc,  32'd0);
        checkOutput("rst_stb",    wbm_stb,  32'd0);
        checkOutput("rst_cab",    wbm_cab,  32'd0);
        checkOutput("rst_sel",    wbm_sel,  32'd0);
        checkOutput("rst_adr",    wbm_adr,  32'd0);
        checkOutput("rst_done",   ss_done,  32'd0);
        checkOutput("rst_cend",   c_end,    32'd0);
        checkOutput("rst_err",    xfer_err, 32'd0);
        checkOutput("rst_dvalid", dvalid,   32'd0);
        checkOutput("rst_dout",   dout,     32'd0);
        wb_rst_n = 1'b1;
        tick();

        $display("[TB] four-word burst from 0x1000");
        applyStimulus(29'h0000_0200, 16'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_stb", wbm_stb, 32'd1);
            checkOutput("t1_we",  wbm_we,  32'd0);
            checkOutput("t1_sel", wbm_sel, 32'hF);
            checkOutput("t1_adr", wbm_adr, 32'h1000 + 32'(4 * i));
            checkOutput("t1_cab", wbm_cab, (i < 3) ? 32'd1 : 32'd0);
            wbm_ack   = 1'b1;
            wbm_dat_i = 32'h1111_0000 + 32'(i);
            tick();
        end
        wbm_ack = 1'b0;
        checkOutput("t1_done", ss_done, 32'd1);
        checkOutput("t1_cend", c_end,   32'd0);
        checkOutput("t1_cyc",  wbm_cyc, 32'd0);
        tick();
        checkOutput("t1_done_off", ss_done, 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_dvalid", dvalid, 32'd1);
            checkOutput("t1_dout",   dout,   32'h1111_0000 + 32'(i));
            drd = 1'b1;
            tick();
        end
        drd = 1'b0;
        checkOutput("t1_empty", dvalid, 32'd0);

        $display("[TB] twelve-word burst against a stalled consumer");
        applyStimulus(29'h0000_0400, 16'd12, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("t2_stb", wbm_stb, 32'd1);
            checkOutput("t2_adr", wbm_adr, 32'h2000 + 32'(4 * i));
            wbm_ack   = 1'b1;
            wbm_dat_i = 32'h2222_0000 + 32'(i);
            tick();
        end
        wbm_ack = 1'b0;
        checkOutput("t2_hold_stb", wbm_stb, 32'd0);
        checkOutput("t2_hold_cyc", wbm_cyc, 32'd1);
        applyStimulus(29'h0000_07FF, 16'd0, 1'b1);
        checkOutput("t2_ignore_stb",  wbm_stb, 32'd0);
        checkOutput("t2_ignore_cyc",  wbm_cyc, 32'd1);
        checkOutput("t2_ignore_done", ss_done, 32'd0);
        tick();
        checkOutput("t2_still_hold", wbm_stb, 32'd0);
        checkOutput("t2_head", dout, 32'h2222_0000);
        drd = 1'b1;
        tick();
        drd = 1'b0;
        checkOutput("t2_resume_stb", wbm_stb, 32'd1);
        checkOutput("t2_resume_adr", wbm_adr, 32'h2020);
        wbm_ack   = 1'b1;
        wbm_dat_i = 32'h2222_0008;
        tick();
        wbm_ack = 1'b0;
        checkOutput("t2_rehold_stb", wbm_stb, 32'd0);
        checkOutput("t2_rehold_cyc", wbm_cyc, 32'd1);
        tick();
        checkOutput("t2_rehold_stay", wbm_stb, 32'd0);
        ackIdx   = 9;
        popIdx   = 1;
        doneSeen = 1'b0;
        for (int c = 0; c < 60 && !(doneSeen && !dvalid); c++) begin
            wbm_ack = wbm_stb;
            drd     = dvalid;
            if (wbm_stb) begin
                checkOutput("t2_drain_adr", wbm_adr, 32'h2000 + 32'(4 * ackIdx));
                wbm_dat_i = 32'h2222_0000 + 32'(ackIdx);
                ackIdx++;
            end
            if (dvalid) begin
                checkOutput("t2_drain_dout", dout, 32'h2222_0000 + 32'(popIdx));
                popIdx++;
            end
            if (ss_done) begin
                doneSeen = 1'b1;
            end
            tick();
        end
        wbm_ack = 1'b0;
        drd     = 1'b0;
        checkOutput("t2_acks",  32'(ackIdx), 32'd12);
        checkOutput("t2_pops",  32'(popIdx), 32'd12);
        checkOutput("t2_done",  32'(doneSeen), 32'd1);
        checkOutput("t2_empty", dvalid, 32'd0);

        $display("[TB] retry on second beat, ack+rty on third");
        applyStimulus(29'h0000_0600, 16'd3, 1'b0);
        checkOutput("t3_adr0", wbm_adr, 32'h3000);
        wbm_ack   = 1'b1;
        wbm_dat_i = 32'h3333_0000;
        tick();
        wbm_ack = 1'b0;
        checkOutput("t3_adr1", wbm_adr, 32'h3004);
        checkOutput("t3_stb1", wbm_stb, 32'd1);
        wbm_rty   = 1'b1;
        wbm_dat_i = 32'hDEAD_BEEF;
        tick();
        wbm_rty = 1'b0;
        checkOutput("t3_gap_stb", wbm_stb, 32'd0);
        checkOutput("t3_gap_cyc", wbm_cyc, 32'd1);
        tick();
        checkOutput("t3_retry_stb", wbm_stb, 32'd1);
        checkOutput("t3_retry_adr", wbm_adr, 32'h3004);
        wbm_ack   = 1'b1;
        wbm_dat_i = 32'h3333_0001;
        tick();
        checkOutput("t3_adr2", wbm_adr, 32'h3008);
        wbm_rty   = 1'b1;
        wbm_dat_i = 32'h3333_0002;
        tick();
        wbm_ack = 1'b0;
        wbm_rty = 1'b0;
        checkOutput("t3_done", ss_done, 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("t3_dout", dout, 32'h3333_0000 + 32'(i));
            drd = 1'b1;
            tick();
        end
        drd = 1'b0;
        checkOutput("t3_empty", dvalid, 32'd0);

        $display("[TB] bus error on third beat of six");
        applyStimulus(29'h0000_0800, 16'd6, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checkOutput("t4_adr", wbm_adr, 32'h4000 + 32'(4 * i));
            wbm_ack   = 1'b1;
            wbm_dat_i = 32'h4444_0000 + 32'(i);
            tick();
        end
        checkOutput("t4_adr_err", wbm_adr, 32'h4008);
        wbm_err   = 1'b1;
        err_clr   = 1'b1;
        wbm_dat_i = 32'h0BAD_0BAD;
        tick();
        wbm_err = 1'b0;
        wbm_ack = 1'b0;
        err_clr = 1'b0;
        checkOutput("t4_done", ss_done,  32'd1);
        checkOutput("t4_cend", c_end,    32'd0);
        checkOutput("t4_cyc",  wbm_cyc,  32'd0);
        checkOutput("t4_err",  xfer_err, 32'd1);
        tick();
        checkOutput("t4_done_off", ss_done,  32'd0);
        checkOutput("t4_sticky",   xfer_err, 32'd1);
        for (int i = 0; i < 2; i++) begin
            checkOutput("t4_dout", dout, 32'h4444_0000 + 32'(i));
            drd = 1'b1;
            tick();
        end
        drd = 1'b0;
        checkOutput("t4_empty", dvalid, 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("t4_clr", xfer_err, 32'd0);

        $display("[TB] zero-length final descriptor");
        applyStimulus(29'h0000_0A00, 16'd0, 1'b1);
        checkOutput("t5_done", ss_done, 32'd1);
        checkOutput("t5_cend", c_end,   32'd1);
        checkOutput("t5_cyc",  wbm_cyc, 32'd0);
        checkOutput("t5_stb",  wbm_stb, 32'd0);
        tick();
        checkOutput("t5_done_off", ss_done, 32'd0);
        checkOutput("t5_cend_off", c_end,   32'd0);
        checkOutput("t5_idle_cyc", wbm_cyc, 32'd0);

        $display("[TB] reset in the middle of a burst");
        applyStimulus(29'h0000_0A00, 16'd8, 1'b0);
        for (int i = 0; i < 2; i++) begin
            wbm_ack   = 1'b1;
            wbm_dat_i = 32'h5555_0000 + 32'(i);
            tick();
        end
        wbm_ack = 1'b0;
        checkOutput("t6_pre_cyc",    wbm_cyc, 32'd1);
        checkOutput("t6_pre_dvalid", dvalid,  32'd1);
        wb_rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_cyc",    wbm_cyc, 32'd0);
        checkOutput("t6_rst_stb",    wbm_stb, 32'd0);
        checkOutput("t6_rst_dvalid", dvalid,  32'd0);
        checkOutput("t6_rst_dout",   dout,    32'd0);
        checkOutput("t6_rst_adr",    wbm_adr, 32'd0);
        tick();
        wb_rst_n = 1'b1;
        tick();
        checkOutput("t6_post_cyc",    wbm_cyc, 32'd0);
        checkOutput("t6_post_done",   ss_done, 32'd0);
        checkOutput("t6_post_dvalid", dvalid,  32'd0);
        applyStimulus(29'h0000_0C00, 16'd1, 1'b1);
        checkOutput("t6_new_stb", wbm_stb, 32'd1);
        checkOutput("t6_new_adr", wbm_adr, 32'h6000);
        checkOutput("t6_new_cab", wbm_cab, 32'd0);
        wbm_ack   = 1'b1;
        wbm_dat_i = 32'h6666_0000;
        tick();
        wbm_ack = 1'b0;
        checkOutput("t6_new_done", ss_done, 32'd1);
        checkOutput("t6_new_cend", c_end,   32'd1);
        tick();
        checkOutput("t6_new_dvalid", dvalid, 32'd1);
        checkOutput("t6_new_dout",   dout,   32'h6666_0000);
        drd = 1'b1;
        tick();
        drd = 1'b0;
        checkOutput("t6_new_empty", dvalid, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
